// File: rtl/memory_access_stage_if.sv
// Data memory bus between the M stage and the data memory.
// The master raises dmem_req with address/controls; the slave answers with dmem_ack (and dmem_rdata for loads) in the same or a later cycle.
interface memory_access_stage_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic          dmem_req;
  logic          dmem_we;
  logic [AW-1:0] dmem_addr;
  logic [DW-1:0] dmem_wdata;
  logic          dmem_ack;
  logic [DW-1:0] dmem_rdata;

  modport master (
    output dmem_req, dmem_we, dmem_addr, dmem_wdata,
    input  dmem_ack, dmem_rdata
  );

  modport slave (
    input  dmem_req, dmem_we, dmem_addr, dmem_wdata,
    output dmem_ack, dmem_rdata
  );
endinterface

// File: rtl/memory_access_stage.sv
// Pipeline M stage: issues data memory accesses, stalls while waiting for ack,
// applies a bounded timeout and misalignment check, and registers the M->W pipeline latch.
module memory_access_stage #(
  parameter int ALUOut_width   = 32,
  parameter int ReadDat_width  = 32,
  parameter int WriteReg_width = 5,
  parameter int TIMEOUT        = 16
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic                      RegWriteM,
  input  logic                      MemtoRegM,
  input  logic                      MemWriteM,
  input  logic [ALUOut_width-1:0]   ALUOutM,
  input  logic [ReadDat_width-1:0]  WriteDataM,
  input  logic [WriteReg_width-1:0] WriteRegM,
  memory_access_stage_if.master     dmem,
  output logic                      StallM,
  output logic                      RegWriteW,
  output logic                      MemtoRegW,
  output logic [ALUOut_width-1:0]   ALUOutW,
  output logic [ReadDat_width-1:0]  ReadDataW,
  output logic [WriteReg_width-1:0] WriteRegW,
  output logic                      MemErr,
  output logic                      fsm_state
);

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_t;

  localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT - 1);

  state_t     state;
  logic [7:0] wait_cnt;

  logic access;
  logic misaligned;
  logic in_wait;
  logic timeout_hit;
  logic req;
  logic complete;
  logic mis_err;

  assign access      = MemtoRegM | MemWriteM;
  assign misaligned  = access & (ALUOutM[1:0] != 2'b00);
  assign in_wait     = (state == WAIT);
  assign timeout_hit = in_wait & ~dmem.dmem_ack & (wait_cnt == TIMEOUT_LAST);
  // Gated by RST so every output is zero while reset is held, even with a live access on the M inputs.
  assign req         = RST & ((~in_wait & access & ~misaligned) | in_wait);
  assign complete    = req & dmem.dmem_ack;
  assign mis_err     = ~in_wait & misaligned;

  assign dmem.dmem_req   = req;
  assign dmem.dmem_we    = req & MemWriteM;
  assign dmem.dmem_addr  = req ? ALUOutM : '0;
  assign dmem.dmem_wdata = req ? WriteDataM : '0;

  assign StallM    = req & ~dmem.dmem_ack & ~timeout_hit;
  assign fsm_state = state;

  // wait_cnt counts the request cycle too, so TIMEOUT bounds the total cycles an access may take.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state     <= IDLE;
      wait_cnt  <= 8'd0;
      RegWriteW <= 1'b0;
      MemtoRegW <= 1'b0;
      ALUOutW   <= '0;
      ReadDataW <= '0;
      WriteRegW <= '0;
      MemErr    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req && !dmem.dmem_ack) begin
            state    <= WAIT;
            wait_cnt <= 8'd1;
          end
        end
        WAIT: begin
          if (dmem.dmem_ack || timeout_hit) begin
            state    <= IDLE;
            wait_cnt <= 8'd0;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end
        default: begin
          state    <= IDLE;
          wait_cnt <= 8'd0;
        end
      endcase

      if (StallM || timeout_hit || mis_err) begin
        RegWriteW <= 1'b0;
        MemtoRegW <= 1'b0;
        ALUOutW   <= '0;
        ReadDataW <= '0;
        WriteRegW <= '0;
      end else begin
        RegWriteW <= RegWriteM;
        MemtoRegW <= MemtoRegM;
        ALUOutW   <= ALUOutM;
        ReadDataW <= (complete && MemtoRegM) ? dmem.dmem_rdata : '0;
        WriteRegW <= WriteRegM;
      end

      MemErr <= MemErr | timeout_hit | mis_err;
    end
  end

endmodule

// File: tb/tb_memory_access_stage.sv
// Directed bench for memory_access_stage: the driver pushes the expected W latch
// contents per cycle; a monitor pops and compares them after every rising edge.
module tb_memory_access_stage;

  logic        CLK;
  logic        RST;
  logic        RegWriteM, MemtoRegM, MemWriteM;
  logic [31:0] ALUOutM, WriteDataM;
  logic [4:0]  WriteRegM;
  logic        StallM, RegWriteW, MemtoRegW, MemErr, fsm_state;
  logic [31:0] ALUOutW, ReadDataW;
  logic [4:0]  WriteRegW;

  memory_access_stage_if #(.AW(32), .DW(32)) bus ();

  memory_access_stage #(
    .ALUOut_width(32), .ReadDat_width(32), .WriteReg_width(5), .TIMEOUT(16)
  ) dut (
    .CLK(CLK), .RST(RST),
    .RegWriteM(RegWriteM), .MemtoRegM(MemtoRegM), .MemWriteM(MemWriteM),
    .ALUOutM(ALUOutM), .WriteDataM(WriteDataM), .WriteRegM(WriteRegM),
    .dmem(bus),
    .StallM(StallM), .RegWriteW(RegWriteW), .MemtoRegW(MemtoRegW),
    .ALUOutW(ALUOutW), .ReadDataW(ReadDataW), .WriteRegW(WriteRegW),
    .MemErr(MemErr), .fsm_state(fsm_state)
  );

  // clock / reset
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int total = 0;
  int bad   = 0;
  logic [71:0] exp_q[$];

  function automatic logic [71:0] wv(input logic rw, mtr, input logic [31:0] alu, rd,
                                     input logic [4:0] wr, input logic err);
    return {rw, mtr, alu, rd, wr, err};
  endfunction

  function automatic logic [71:0] w_act();
    return {RegWriteW, MemtoRegW, ALUOutW, ReadDataW, WriteRegW, MemErr};
  endfunction

  task automatic chk(input string name, input logic [71:0] act, input logic [71:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // scoreboard monitor
  always @(posedge CLK) begin
    #1;
    if (exp_q.size() != 0) chk("w_latch", w_act(), exp_q.pop_front());
  end

  // driver: apply one M-stage cycle, check combinational outputs, queue the W result
  task automatic step(input logic rw, mtr, mw, input logic [31:0] alu, wd,
                      input logic [4:0] wr, input logic ack, input logic [31:0] rd,
                      input logic e_req, e_stall, input logic [71:0] e_w);
    RegWriteM = rw; MemtoRegM = mtr; MemWriteM = mw;
    ALUOutM = alu; WriteDataM = wd; WriteRegM = wr;
    bus.dmem_ack = ack; bus.dmem_rdata = rd;
    #1;
    chk("dmem_req", 72'(bus.dmem_req), 72'(e_req));
    chk("stall", 72'(StallM), 72'(e_stall));
    chk("dmem_addr", 72'(bus.dmem_addr), e_req ? 72'(alu) : 72'd0);
    chk("dmem_we", 72'(bus.dmem_we), 72'(e_req & mw));
    chk("dmem_wdata", 72'(bus.dmem_wdata), e_req ? 72'(wd) : 72'd0);
    exp_q.push_back(e_w);
    @(negedge CLK);
  endtask

  logic [71:0] bubble0, bubble1;

  initial begin
    bubble0 = wv(0, 0, 0, 0, 0, 0);
    bubble1 = wv(0, 0, 0, 0, 0, 1);
    RST = 1'b0;
    RegWriteM = 0; MemtoRegM = 0; MemWriteM = 0;
    ALUOutM = 0; WriteDataM = 0; WriteRegM = 0;
    bus.dmem_ack = 0; bus.dmem_rdata = 0;
    @(negedge CLK);
    @(negedge CLK);
    chk("reset_w", w_act(), bubble0);
    chk("reset_fsm", 72'(fsm_state), 72'd0);
    RST = 1'b1;

    // ALU op passes straight through
    step(1, 0, 0, 32'h15, 0, 5'd7, 0, 0, 0, 0, wv(1, 0, 32'h15, 0, 7, 0));
    // zero-wait load
    step(1, 1, 0, 32'h100, 0, 5'd3, 1, 32'hDEADBEEF, 1, 0, wv(1, 1, 32'h100, 32'hDEADBEEF, 3, 0));
    // stray ack with no request is ignored
    step(1, 0, 0, 32'h42, 0, 5'd9, 1, 32'h1234, 0, 0, wv(1, 0, 32'h42, 0, 9, 0));

    // store acked after 3 stall cycles
    step(0, 0, 1, 32'h200, 32'h55, 5'd4, 0, 0, 1, 1, bubble0);
    chk("store_fsm_wait", 72'(fsm_state), 72'd1);
    step(0, 0, 1, 32'h200, 32'h55, 5'd4, 0, 0, 1, 1, bubble0);
    step(0, 0, 1, 32'h200, 32'h55, 5'd4, 0, 0, 1, 1, bubble0);
    step(0, 0, 1, 32'h200, 32'h55, 5'd4, 1, 0, 1, 0, wv(0, 0, 32'h200, 0, 4, 0));
    chk("store_fsm_idle", 72'(fsm_state), 72'd0);

    // misaligned load: no request, bubble, error
    step(1, 1, 0, 32'h102, 0, 5'd5, 0, 0, 0, 0, bubble1);
    // error is sticky, later accesses still work
    step(1, 1, 0, 32'h104, 0, 5'd6, 1, 32'h0BADF00D, 1, 0, wv(1, 1, 32'h104, 32'h0BADF00D, 6, 1));

    // reset in the middle of a wait
    step(1, 1, 0, 32'h400, 0, 5'd2, 0, 0, 1, 1, bubble1);
    step(1, 1, 0, 32'h400, 0, 5'd2, 0, 0, 1, 1, bubble1);
    chk("pre_reset_fsm", 72'(fsm_state), 72'd1);
    #2 RST = 1'b0;
    #1;
    chk("async_reset_w", w_act(), bubble0);
    chk("async_reset_req", 72'(bus.dmem_req), 72'd0);
    chk("async_reset_stall", 72'(StallM), 72'd0);
    chk("async_reset_fsm", 72'(fsm_state), 72'd0);
    @(negedge CLK);
    RST = 1'b1;
    // first edge after reset behaves as IDLE with the held load
    step(1, 1, 0, 32'h400, 0, 5'd2, 1, 32'hCAFEF00D, 1, 0, wv(1, 1, 32'h400, 32'hCAFEF00D, 2, 0));

    // load never acked: 15 stall cycles, timeout on the 16th
    for (int i = 0; i < 15; i++)
      step(1, 1, 0, 32'h300, 0, 5'd8, 0, 0, 1, 1, bubble0);
    step(1, 1, 0, 32'h300, 0, 5'd8, 0, 0, 1, 0, bubble1);
    chk("timeout_fsm_idle", 72'(fsm_state), 72'd0);
    step(1, 0, 0, 32'h7, 0, 5'd1, 0, 0, 0, 0, wv(1, 0, 32'h7, 0, 1, 1));

    @(negedge CLK);
    chk("queue_drained", 72'(exp_q.size()), 72'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

endmodule
